// File: rtl/mac_feeder.sv
// mac_feeder: sequences one unsigned dot product of VEC_LEN operand pairs.
// It pops A and B together, clears the MAC, streams the pairs into it and
// captures the final accumulator into result.
//
// state   | meaning
// --------+----------------------------------------------------------
// IDLE    | waiting for start
// CLEAR   | mac_clr high for one cycle, issue counter reset
// FEED    | pop one pair per cycle while both FIFOs have data
// DRAIN   | last popped pair is on rdata, last mac_en cycle
// CAPTURE | accumulator holds the final sum, load result and pulse done
module mac_feeder #(
  parameter int DATA_WIDTH = 8,
  parameter int VEC_LEN    = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  output logic                      busy,
  output logic                      done,
  output logic                      a_rden,
  input  logic [DATA_WIDTH-1:0]     a_rdata,
  input  logic                      a_empty,
  output logic                      b_rden,
  input  logic [DATA_WIDTH-1:0]     b_rdata,
  input  logic                      b_empty,
  output logic                      mac_en,
  output logic                      mac_clr,
  output logic [DATA_WIDTH-1:0]     mac_a,
  output logic [DATA_WIDTH-1:0]     mac_b,
  input  logic [3*DATA_WIDTH-1:0]   mac_cout,
  output logic [3*DATA_WIDTH-1:0]   result,
  output logic                      result_valid
);

  localparam int CW = $clog2(VEC_LEN + 1);
  localparam logic [CW-1:0] LIMIT = CW'(VEC_LEN);
  localparam logic [CW-1:0] LAST  = CW'(VEC_LEN - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CLEAR   = 3'd1,
    FEED    = 3'd2,
    DRAIN   = 3'd3,
    CAPTURE = 3'd4
  } state_t;

  state_t          state;
  logic [CW-1:0]   count;
  logic            pop;

  // Both FIFOs are always popped together, and only when both hold data.
  assign pop     = (state == FEED) && !a_empty && !b_empty && (count < LIMIT);
  assign a_rden  = pop;
  assign b_rden  = pop;
  assign busy    = (state != IDLE);
  assign mac_clr = (state == CLEAR);

  // Operands are zeroed outside accumulate cycles so the MAC never sees stale data.
  assign mac_a = mac_en ? a_rdata : '0;
  assign mac_b = mac_en ? b_rdata : '0;

  // Sequencer: state, issue counter, accumulate enable and result capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      count        <= '0;
      result       <= '0;
      done         <= 1'b0;
      result_valid <= 1'b0;
      mac_en       <= 1'b0;
    end else begin
      // rdata is valid the cycle after a pop, which is exactly when mac_en is high.
      mac_en       <= pop;
      done         <= 1'b0;
      result_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (start) state <= CLEAR;
        end
        CLEAR: begin
          count <= '0;
          state <= FEED;
        end
        FEED: begin
          if (pop) begin
            count <= count + 1'b1;
            if (count == LAST) state <= DRAIN;
          end
        end
        DRAIN: begin
          state <= CAPTURE;
        end
        CAPTURE: begin
          result       <= mac_cout;
          done         <= 1'b1;
          result_valid <= 1'b1;
          state        <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mac_feeder.sv
// Directed bench for mac_feeder: FIFO and MAC models around two instances
// (default VEC_LEN=8 and VEC_LEN=1), cycle numbering relative to the start cycle.
module tb_mac_feeder;

  localparam int DW = 8;
  localparam int RW = 3 * DW;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic          rst, start;
  logic          busy, done, a_rden, b_rden, mac_en, mac_clr, result_valid;
  logic [DW-1:0] a_rdata, b_rdata, mac_a, mac_b;
  logic          a_empty, b_empty;
  logic [RW-1:0] mac_cout, result;

  // FIFO models: data appears on rdata the cycle after a pop
  logic [DW-1:0] a_mem [0:127];
  logic [DW-1:0] b_mem [0:127];
  logic [6:0]    a_wp = '0, b_wp = '0;
  logic [6:0]    a_rp = '0, b_rp = '0;
  logic          b_stall, fifo_flush;

  assign a_empty = (a_wp == a_rp);
  assign b_empty = (b_wp == b_rp) || b_stall;

  always @(posedge clk) begin
    if (fifo_flush) begin
      a_rp <= a_wp;
      b_rp <= b_wp;
    end else begin
      if (a_rden) begin
        a_rdata <= a_mem[a_rp];
        a_rp    <= a_rp + 7'd1;
      end
      if (b_rden) begin
        b_rdata <= b_mem[b_rp];
        b_rp    <= b_rp + 7'd1;
      end
    end
  end

  // MAC model
  logic [RW-1:0] acc = '0;
  assign mac_cout = acc;
  always @(posedge clk) begin
    if (mac_clr) acc <= '0;
    else if (mac_en) acc <= acc + RW'(mac_a) * RW'(mac_b);
  end

  mac_feeder #(.DATA_WIDTH(DW), .VEC_LEN(8)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .a_rden(a_rden), .a_rdata(a_rdata), .a_empty(a_empty),
    .b_rden(b_rden), .b_rdata(b_rdata), .b_empty(b_empty),
    .mac_en(mac_en), .mac_clr(mac_clr), .mac_a(mac_a), .mac_b(mac_b),
    .mac_cout(mac_cout), .result(result), .result_valid(result_valid)
  );

  // VEC_LEN=1 instance with constant operands 7 and 9
  logic          start1, busy1, done1, a1_rden, b1_rden, mac1_en, mac1_clr, rv1;
  logic [DW-1:0] a1_rdata, b1_rdata, mac1_a, mac1_b;
  logic          a1_empty, b1_empty;
  logic [RW-1:0] acc1 = '0, result1;
  assign a1_rdata = 8'd7;
  assign b1_rdata = 8'd9;
  assign a1_empty = 1'b0;
  assign b1_empty = 1'b0;

  always @(posedge clk) begin
    if (mac1_clr) acc1 <= '0;
    else if (mac1_en) acc1 <= acc1 + RW'(mac1_a) * RW'(mac1_b);
  end

  mac_feeder #(.DATA_WIDTH(DW), .VEC_LEN(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .busy(busy1), .done(done1),
    .a_rden(a1_rden), .a_rdata(a1_rdata), .a_empty(a1_empty),
    .b_rden(b1_rden), .b_rdata(b1_rdata), .b_empty(b1_empty),
    .mac_en(mac1_en), .mac_clr(mac1_clr), .mac_a(mac1_a), .mac_b(mac1_b),
    .mac_cout(acc1), .result(result1), .result_valid(rv1)
  );

  int n_checks = 0, n_errors = 0;
  int t0 = 0;
  int n_apop, n_bpop, n_en, n_clr, n_done, n_bad, first_en, last_en, busy_at_done;
  int done_cyc [0:3];
  int clr_cyc  [0:3];
  logic [RW-1:0] res_done [0:3];
  int n1_en, first1_en, n1_pop, n1_done, done1_cyc;
  logic [RW-1:0] res1;
  int stall_arm, stall_rem;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic clear_stats();
    n_apop = 0; n_bpop = 0; n_en = 0; n_clr = 0; n_done = 0; n_bad = 0;
    first_en = -1; last_en = -1; busy_at_done = -1;
    for (int i = 0; i < 4; i++) begin
      done_cyc[i] = -1; clr_cyc[i] = -1; res_done[i] = '0;
    end
    n1_en = 0; first1_en = -1; n1_pop = 0; n1_done = 0; done1_cyc = -1; res1 = '0;
  endtask

  task automatic push(input logic [DW-1:0] a, input logic [DW-1:0] b);
    a_mem[a_wp] = a; a_wp = a_wp + 7'd1;
    b_mem[b_wp] = b; b_wp = b_wp + 7'd1;
  endtask

  // One cycle: sample at the falling edge, then move inputs just after the rising edge.
  task automatic step();
    int rel;
    @(negedge clk);
    rel = cyc - t0;
    if (a_rden) n_apop++;
    if (b_rden) n_bpop++;
    if (a_rden !== b_rden) n_bad++;
    if (mac_en && mac_clr) n_bad++;
    if (!mac_en && (mac_a != '0 || mac_b != '0)) n_bad++;
    if (done !== result_valid) n_bad++;
    if (mac_en) begin
      if (n_en == 0) first_en = rel;
      last_en = rel;
      n_en++;
    end
    if (mac_clr) begin
      if (n_clr < 4) clr_cyc[n_clr] = rel;
      n_clr++;
    end
    if (done) begin
      if (n_done < 4) begin
        done_cyc[n_done] = rel;
        res_done[n_done] = result;
      end
      busy_at_done = int'(busy);
      n_done++;
    end
    if (mac1_en) begin
      if (n1_en == 0) first1_en = rel;
      n1_en++;
    end
    if (a1_rden) n1_pop++;
    if (done1) begin
      done1_cyc = rel;
      res1 = result1;
      n1_done++;
    end
    @(posedge clk); #1;
    if (stall_arm != 0 && n_bpop == 4) begin
      stall_arm = 0;
      stall_rem = 3;
    end
    b_stall = (stall_rem > 0);
    if (stall_rem > 0) stall_rem--;
  endtask

  task automatic run();
    start = 1'b1; t0 = cyc; clear_stats();
    step();
    start = 1'b0;
    for (int i = 0; i < 60 && n_done == 0; i++) step();
    repeat (3) step();
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; start1 = 1'b0; b_stall = 1'b0; fifo_flush = 1'b0;
    stall_arm = 0; stall_rem = 0;
    clear_stats();

    // reset values
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_rv", result_valid, 0);
    chk("rst_a_rden", a_rden, 0);
    chk("rst_b_rden", b_rden, 0);
    chk("rst_mac_en", mac_en, 0);
    chk("rst_mac_clr", mac_clr, 0);
    chk("rst_result", result, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // basic: A=1..8, B=2 -> 72
    for (int i = 1; i <= 8; i++) push(DW'(i), 8'd2);
    run();
    chk("basic_clr_cyc", clr_cyc[0], 1);
    chk("basic_first_en", first_en, 3);
    chk("basic_last_en", last_en, 10);
    chk("basic_n_en", n_en, 8);
    chk("basic_done_cyc", done_cyc[0], 12);
    chk("basic_result", res_done[0], 72);
    chk("basic_busy_at_done", busy_at_done, 0);
    chk("basic_pops_a", n_apop, 8);
    chk("basic_pops_b", n_bpop, 8);
    chk("basic_n_done", n_done, 1);
    chk("basic_protocol", n_bad, 0);

    // B empty for 3 cycles after the 4th pair
    for (int i = 1; i <= 8; i++) push(DW'(i), 8'd2);
    stall_arm = 1;
    run();
    chk("stall_done_cyc", done_cyc[0], 15);
    chk("stall_result", res_done[0], 72);
    chk("stall_last_en", last_en, 13);
    chk("stall_pops_a", n_apop, 8);
    chk("stall_pops_b", n_bpop, 8);
    chk("stall_n_done", n_done, 1);
    chk("stall_protocol", n_bad, 0);

    // max operands, then all ones to prove the MAC is cleared
    for (int i = 0; i < 8; i++) push(8'd255, 8'd255);
    run();
    chk("max_result", res_done[0], 520200);
    chk("max_done_cyc", done_cyc[0], 12);
    for (int i = 0; i < 8; i++) push(8'd1, 8'd1);
    run();
    chk("ones_result", res_done[0], 8);

    // start held high through the done cycle: one extra run, not queued ones
    for (int i = 1; i <= 8; i++) push(DW'(i), 8'd2);
    for (int i = 1; i <= 8; i++) push(DW'(i), 8'd3);
    start = 1'b1; t0 = cyc; clear_stats();
    repeat (13) step();
    start = 1'b0;
    for (int i = 0; i < 60 && n_done < 2; i++) step();
    repeat (3) step();
    chk("dbl_done0_cyc", done_cyc[0], 12);
    chk("dbl_result0", res_done[0], 72);
    chk("dbl_clr1_cyc", clr_cyc[1], 13);
    chk("dbl_n_clr", n_clr, 2);
    chk("dbl_done1_cyc", done_cyc[1], 24);
    chk("dbl_result1", res_done[1], 108);
    chk("dbl_n_done", n_done, 2);
    chk("dbl_pops", n_apop, 16);
    chk("dbl_protocol", n_bad, 0);

    // reset in cycle 6 mid-FEED
    for (int i = 1; i <= 8; i++) push(DW'(i), 8'd2);
    start = 1'b1; t0 = cyc; clear_stats();
    step();
    start = 1'b0;
    repeat (5) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_a_rden", a_rden, 0);
    chk("mid_rst_b_rden", b_rden, 0);
    chk("mid_rst_mac_en", mac_en, 0);
    chk("mid_rst_result", result, 0);
    chk("mid_rst_pops", n_apop, 5);
    @(posedge clk); #1;
    fifo_flush = 1'b1;
    @(posedge clk); #1;
    fifo_flush = 1'b0;
    for (int i = 1; i <= 8; i++) push(DW'(i), DW'(i));
    run();
    chk("after_rst_result", res_done[0], 204);
    chk("after_rst_done_cyc", done_cyc[0], 12);

    // VEC_LEN=1: 7*9
    start1 = 1'b1; t0 = cyc; clear_stats();
    step();
    start1 = 1'b0;
    for (int i = 0; i < 30 && n1_done == 0; i++) step();
    repeat (3) step();
    chk("v1_first_en", first1_en, 3);
    chk("v1_n_en", n1_en, 1);
    chk("v1_done_cyc", done1_cyc, 5);
    chk("v1_result", res1, 63);
    chk("v1_pops", n1_pop, 1);
    chk("v1_n_done", n1_done, 1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mac_feeder.md
Name: mac_feeder

Overview:
- Upstream sequencer for one MAC unit. Computes one unsigned dot product of length VEC_LEN per start command.
- Pops paired operands from an A FIFO and a B FIFO, clears the MAC, then streams the operands into the MAC.
- After the last operand it captures the MAC accumulator into a result register.
- Sits between the operand FIFOs and the MAC: drives the MAC's En/Clr/Ain/Bin and reads back its accumulator.

Parameters:
- DATA_WIDTH, 8, operand width; the result is 3*DATA_WIDTH bits.
- VEC_LEN, 8, products per dot product (>=1); the issue counter is $clog2(VEC_LEN+1) bits.

Ports:
- clk  input  1  system clock, all logic on posedge.
- rst  input  1  reset.
- start  input  1  begin one dot product; sampled only in IDLE.
- busy  output  1  high whenever state != IDLE.
- done  output  1  one-cycle pulse when result loads.
- a_rden  output  1  pop A FIFO.
- a_rdata  input  DATA_WIDTH  A FIFO data, valid the cycle after a_rden.
- a_empty  input  1  A FIFO empty.
- b_rden  output  1  pop B FIFO.
- b_rdata  input  DATA_WIDTH  B FIFO data, valid the cycle after b_rden.
- b_empty  input  1  B FIFO empty.
- mac_en  output  1  MAC accumulate enable.
- mac_clr  output  1  MAC clear.
- mac_a  output  DATA_WIDTH  MAC A operand.
- mac_b  output  DATA_WIDTH  MAC B operand.
- mac_cout  input  3*DATA_WIDTH  MAC accumulator value.
- result  output  3*DATA_WIDTH  captured dot product; holds until the next capture.
- result_valid  output  1  one-cycle pulse, coincident with done.

Behaviour:
- Clocking/reset: one clock; reset is synchronous and active-high.
- Reset values: state IDLE, issue counter 0, result 0. busy, done, result_valid, a_rden, b_rden, mac_en and mac_clr are all 0.
- Reset mid-operation: abandon everything and return to IDLE next cycle. No further pops; an in-flight mac_en is dropped. result keeps 0 (reset value).
- FSM states: IDLE, CLEAR, FEED, DRAIN, CAPTURE.
- IDLE: start=1 -> CLEAR.
- CLEAR: mac_clr=1 for exactly one cycle; counter <= 0; -> FEED.
- FEED:
  - Pop condition: !a_empty && !b_empty && counter < VEC_LEN.
  - On pop, a_rden = b_rden = 1 in the same cycle (combinational from state/counter/empties) and counter++.
  - A and B are always popped together; never pop one FIFO alone.
  - Popping the VEC_LEN-th pair -> DRAIN.
  - Otherwise stay in FEED; stall indefinitely while either FIFO is empty.
- DRAIN: one cycle (the last mac_en occurs here); -> CAPTURE.
- CAPTURE: one cycle; mac_cout holds the final sum. At the closing edge: result <= mac_cout, done <= 1, result_valid <= 1, state <= IDLE.
- mac_en: register of (a_rden & b_rden), i.e. high exactly in the cycle the popped data is on rdata.
- mac_a/mac_b: a_rdata/b_rdata when mac_en=1, else 0.
- mac_en and mac_clr are never high in the same cycle.
- Latency, no stalls, start in cycle 0:
  - mac_clr in cycle 1.
  - pops in cycles 2..VEC_LEN+1.
  - mac_en in cycles 3..VEC_LEN+2.
  - CAPTURE in cycle VEC_LEN+3.
  - done/result_valid in cycle VEC_LEN+4 (state IDLE).
  - Each stall cycle adds one cycle.
- start while busy is ignored (not queued). start during the done cycle is accepted: IDLE -> CLEAR.
- Arithmetic: unsigned. Worst case is VEC_LEN*(2^DATA_WIDTH-1)^2, which must fit in 3*DATA_WIDTH bits; no saturation (with the defaults, 520200 < 2^24). The block performs no arithmetic itself.
- done and result_valid are never high for more than one cycle.

Test Plan:
- Basic: DATA_WIDTH=8, VEC_LEN=8, A=1..8, B=all 2, FIFOs pre-filled, start at cycle 0 -> mac_en cycles 3..10, done in cycle 12, result=72, busy low in cycle 12.
- Stall: same data, but the B FIFO reports empty for 3 cycles after the 4th pair -> no rden during the stall, done in cycle 15, result=72, exactly 8 pops per FIFO.
- Max values: all A=B=255 -> result=520200; then a second run with A=B=1 -> result=8 (proves CLEAR resets the MAC).
- start asserted every cycle while busy -> exactly one run, one done pulse. start in the done cycle -> mac_clr on the next cycle and a second correct result.
- Reset at cycle 6 mid-FEED -> cycle 7 IDLE, busy=0, no rden/mac_en, result=0. A new start then runs normally on refilled FIFOs.
- VEC_LEN=1, A=7, B=9 -> single mac_en in cycle 3, done in cycle 5, result=63.
